// File: rtl/lif_chain_if.sv
// Bus bundle for lif_chain: control/stimulus inputs and spike/state outputs.
// master drives the stimulus side, slave is the neuron chain itself.
interface lif_chain_if #(
    parameter int N_NEURONS = 3,
    parameter int WIDTH     = 8
);
    logic                         en;
    logic [WIDTH-1:0]             current;
    logic [WIDTH-1:0]             threshold;
    logic [WIDTH-1:0]             chain_weight;
    logic                         cnt_clr;
    logic [N_NEURONS-1:0]         spikes;
    logic [N_NEURONS*WIDTH-1:0]   state_flat;
    logic [15:0]                  spike_count;

    modport master (
        output en, current, threshold, chain_weight, cnt_clr,
        input  spikes, state_flat, spike_count
    );

    modport slave (
        input  en, current, threshold, chain_weight, cnt_clr,
        output spikes, state_flat, spike_count
    );
endinterface

// File: rtl/lif_chain.sv
// Chain of leaky integrate-and-fire neurons. Neuron 0 integrates the external
// current; neuron i>0 integrates chain_weight on cycles where neuron i-1's
// registered spike is high. Shift leak, saturating sum, absolute refractory
// period, global enable.
// Optional macro LIF_CHAIN_SPIKE_CNT_EN builds the 16-bit saturating counter of
// last-neuron spikes; without it spike_count is tied to zero and cnt_clr unused.
module lif_chain #(
    parameter int N_NEURONS  = 3,
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRACTORY = 2
) (
    input  logic       clk,
    input  logic       rst,
    lif_chain_if.slave bus
);
    localparam logic [3:0] REFR_LOAD = 4'(REFRACTORY);

    logic [WIDTH-1:0] r_state [N_NEURONS];
    logic [3:0]       r_refr  [N_NEURONS];
    logic             r_spike [N_NEURONS];
    logic             w_fire  [N_NEURONS];

    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_leaked;
        logic [WIDTH:0]   w_sum;

        if (gi == 0) begin : g_src
            assign w_in = bus.current;
        end else begin : g_hop
            assign w_in = r_spike[gi-1] ? bus.chain_weight : '0;
        end

        // leaked value never exceeds state, so the subtraction cannot borrow
        assign w_leaked = r_state[gi] - (r_state[gi] >> LEAK_SHIFT);
        assign w_sum    = {1'b0, w_leaked} + {1'b0, w_in};
        assign w_fire[gi] = (r_refr[gi] == '0) && (r_state[gi] >= bus.threshold);

        // Per-neuron update: refractory clamp, then fire, then leaky integrate
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state[gi] <= '0;
                r_refr[gi]  <= '0;
                r_spike[gi] <= 1'b0;
            end else if (bus.en) begin
                if (r_refr[gi] != '0) begin
                    r_state[gi] <= '0;
                    r_refr[gi]  <= r_refr[gi] - 4'd1;
                    r_spike[gi] <= 1'b0;
                end else if (w_fire[gi]) begin
                    r_state[gi] <= '0;
                    r_refr[gi]  <= REFR_LOAD;
                    r_spike[gi] <= 1'b1;
                end else begin
                    r_state[gi] <= w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
                    r_spike[gi] <= 1'b0;
                end
            end
        end
    end

    // Pack per-neuron registers onto the flat output buses
    always_comb begin
        bus.spikes     = '0;
        bus.state_flat = '0;
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            bus.spikes[i]                    = r_spike[i];
            bus.state_flat[i*WIDTH +: WIDTH] = r_state[i];
        end
    end

`ifdef LIF_CHAIN_SPIKE_CNT_EN
    logic [15:0] r_count;

    // Count last-neuron firings; clear beats increment, holds at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (bus.cnt_clr) begin
            r_count <= '0;
        end else if (bus.en && w_fire[N_NEURONS-1] && (r_count != '1)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign bus.spike_count = r_count;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = bus.cnt_clr;
    assign bus.spike_count  = '0;
`endif
endmodule

// File: tb/tb_lif_chain.sv
// Self-checking bench for lif_chain: directed scenarios plus randomized
// stimulus against an arithmetic reference model of the neuron chain.
module tb_lif_chain;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int LS = 1;
    localparam int RF = 2;
    localparam int MAXV = (1 << W) - 1;
`ifdef LIF_CHAIN_SPIKE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sat_rst;

    lif_chain_if #(.N_NEURONS(N), .WIDTH(W)) bif ();
    lif_chain_if #(.N_NEURONS(1), .WIDTH(W)) sif ();

    lif_chain #(.N_NEURONS(N), .WIDTH(W), .LEAK_SHIFT(LS), .REFRACTORY(RF)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Single always-firing neuron used to reach counter saturation quickly
    lif_chain #(.N_NEURONS(1), .WIDTH(W), .LEAK_SHIFT(LS), .REFRACTORY(0)) u_sat (
        .clk (clk),
        .rst (sat_rst),
        .bus (sif)
    );

    int checks = 0;
    int errors = 0;

    int m_state [N];
    int m_refr  [N];
    int m_spk   [N];
    int m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: one enabled edge applies refractory/fire/integrate rules to
    // every neuron using the values from before the edge.
    task automatic model_step(input bit r, input bit e, input int cur, input int thr,
                              input int wt, input bit clr);
        int ns [N];
        int nr [N];
        int nk [N];
        int in_i;
        int v;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_state[i] = 0; m_refr[i] = 0; m_spk[i] = 0;
            end
            m_cnt = 0;
            return;
        end
        if (CNT_ON && clr) m_cnt = 0;
        if (!e) return;
        for (int i = 0; i < N; i++) begin
            in_i = (i == 0) ? cur : (m_spk[i-1] != 0 ? wt : 0);
            if (m_refr[i] > 0) begin
                ns[i] = 0; nr[i] = m_refr[i] - 1; nk[i] = 0;
            end else if (m_state[i] >= thr) begin
                ns[i] = 0; nr[i] = RF; nk[i] = 1;
            end else begin
                v = m_state[i] - m_state[i] / (1 << LS) + in_i;
                ns[i] = (v > MAXV) ? MAXV : v;
                nr[i] = 0; nk[i] = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_state[i] = ns[i]; m_refr[i] = nr[i]; m_spk[i] = nk[i];
        end
        if (CNT_ON && !clr && nk[N-1] == 1 && m_cnt < 65535) m_cnt++;
    endtask

    function automatic logic [N*W-1:0] model_flat();
        logic [N*W-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) f[i*W +: W] = m_state[i][W-1:0];
        return f;
    endfunction

    function automatic logic [N-1:0] model_spikes();
        logic [N-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s[i] = (m_spk[i] != 0);
        return s;
    endfunction

    // Drive one cycle of stimulus, advance the model, compare all outputs
    task automatic step(input bit r, input bit e, input int cur, input int thr,
                        input int wt, input bit clr);
        rst              = r;
        bif.en           = e;
        bif.current      = cur[W-1:0];
        bif.threshold    = thr[W-1:0];
        bif.chain_weight = wt[W-1:0];
        bif.cnt_clr      = clr;
        @(posedge clk);
        model_step(r, e, cur, thr, wt, clr);
        #1;
        check("model_spikes", 32'(bif.spikes), 32'(model_spikes()));
        check("model_state", 32'(bif.state_flat), 32'(model_flat()));
        check("model_count", 32'(bif.spike_count), 32'(m_cnt));
    endtask

    initial begin
        int exp0 [8];
        int expk [8];
        int cur;
        int thr;
        int wt;

        sat_rst          = 1'b1;
        sif.en           = 1'b0;
        sif.current      = '0;
        sif.threshold    = '0;
        sif.chain_weight = '0;
        sif.cnt_clr      = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0; m_refr[i] = 0; m_spk[i] = 0;
        end
        m_cnt = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 55, 3, 9, 0);
        check("rst_spikes", 32'(bif.spikes), 32'd0);
        check("rst_state", 32'(bif.state_flat), 32'd0);
        check("rst_count", 32'(bif.spike_count), 32'd0);

        // Basic integrate/fire/refractory, period 5
        exp0 = '{100, 150, 0, 0, 0, 100, 150, 0};
        expk = '{0, 0, 1, 0, 0, 0, 0, 1};
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 100, 127, 0, 0);
            check("tp1_state0", 32'(bif.state_flat[W-1:0]), 32'(exp0[k]));
            check("tp1_spike0", 32'(bif.spikes[0]), 32'(expk[k]));
        end

        // Saturation at 255 rather than wrapping to 44
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 200, 255, 0, 0);
        check("sat_s1", 32'(bif.state_flat[W-1:0]), 32'd200);
        step(0, 1, 200, 255, 0, 0);
        check("sat_s2", 32'(bif.state_flat[W-1:0]), 32'd255);
        step(0, 1, 200, 255, 0, 0);
        check("sat_fire_state", 32'(bif.state_flat[W-1:0]), 32'd0);
        check("sat_fire_spike", 32'(bif.spikes[0]), 32'd1);

        // Chain propagation
        step(1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            step(0, 1, 100, 127, 128, 0);
            if (k == 3) check("chain_spk0", 32'(bif.spikes), 32'b001);
            if (k == 4) check("chain_state1", 32'(bif.state_flat[2*W-1:W]), 32'd128);
            if (k == 5) check("chain_spk1", 32'(bif.spikes), 32'b010);
            if (k == 6) check("chain_state2", 32'(bif.state_flat[3*W-1:2*W]), 32'd128);
            if (k == 7) begin
                check("chain_spk2", 32'(bif.spikes), 32'b100);
                check("chain_count", 32'(bif.spike_count), CNT_ON ? 32'd1 : 32'd0);
            end
        end

        // Freeze with en low mid-integration
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 100, 127, 0, 0);
        step(0, 1, 100, 127, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, $urandom_range(0, 255), 127, 0, 0);
            check("frz_state0", 32'(bif.state_flat[W-1:0]), 32'd150);
            check("frz_spikes", 32'(bif.spikes), 32'd0);
        end
        step(0, 1, 100, 127, 0, 0);
        check("resume_fire", 32'(bif.spikes[0]), 32'd1);
        step(0, 1, 100, 127, 0, 0);
        check("resume_refr", 32'(bif.state_flat[W-1:0]), 32'd0);

        // Reset while refractory abandons the remaining clamp cycle
        step(1, 1, 100, 127, 0, 0);
        check("rstr_state", 32'(bif.state_flat), 32'd0);
        check("rstr_spikes", 32'(bif.spikes), 32'd0);
        step(0, 1, 100, 127, 0, 0);
        check("rstr_restart", 32'(bif.state_flat[W-1:0]), 32'd100);
        step(0, 1, 100, 127, 0, 0);
        check("rstr_next", 32'(bif.state_flat[W-1:0]), 32'd150);

        // Randomized stimulus against the model
        for (int k = 0; k < 600; k++) begin
            cur = $urandom_range(0, 255);
            thr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(60, 255);
            wt  = $urandom_range(0, 255);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 6) != 0), cur, thr, wt,
                 ($urandom_range(0, 29) == 0));
        end

        // Counter saturation on the always-firing single neuron
        rst    = 1'b1;
        bif.en = 1'b0;
        @(posedge clk);
        #1;
        sat_rst       = 1'b0;
        sif.en        = 1'b1;
        sif.threshold = '0;
        repeat (65534) @(posedge clk);
        #1;
        check("cnt_fffe", 32'(sif.spike_count), CNT_ON ? 32'hFFFE : 32'd0);
        check("cnt_spk", 32'(sif.spikes), 32'd1);
        @(posedge clk);
        #1;
        check("cnt_ffff", 32'(sif.spike_count), CNT_ON ? 32'hFFFF : 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("cnt_hold", 32'(sif.spike_count), CNT_ON ? 32'hFFFF : 32'd0);
        sif.cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        check("cnt_clr_wins", 32'(sif.spike_count), 32'd0);
        sif.cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        check("cnt_after_clr", 32'(sif.spike_count), CNT_ON ? 32'd1 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
